// File: rtl/mtc_link_deframer_if.sv
// Link-side beat stream and packet-side output handshake for one SL link.
//
// Handshake: the link side has no back-pressure; a beat is taken on every
// rising edge where link_valid=1, and link_sof is only meaningful with it.
// The packet side is valid/ready: a packet transfers on a rising edge where
// mtc_valid_o=1 and mtc_ready_i=1; once mtc_valid_o is raised, mtc_o and
// mtc_valid_o hold until that transfer happens.
interface mtc_link_deframer_if #(
    parameter int LINK_WIDTH = 32,
    parameter int PKT_WIDTH  = 72
);
    logic [LINK_WIDTH-1:0] link_data;
    logic                  link_valid;
    logic                  link_sof;
    logic [PKT_WIDTH-1:0]  mtc_o;
    logic                  mtc_valid_o;
    logic                  mtc_ready_i;

    // Drives beats and consumes packets.
    modport master (
        output link_data, link_valid, link_sof, mtc_ready_i,
        input  mtc_o, mtc_valid_o
    );

    // The deframer itself.
    modport slave (
        input  link_data, link_valid, link_sof, mtc_ready_i,
        output mtc_o, mtc_valid_o
    );
endinterface

// File: rtl/mtc_link_deframer.sv
// Reassembles MTC2SL packets from the per-link beat stream, drops null
// packets and framing errors, and buffers good packets in a small
// first-word-fall-through FIFO with registered outputs.
module mtc_link_deframer #(
    parameter int LINK_WIDTH = 32,
    parameter int PKT_WIDTH  = 72,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    mtc_link_deframer_if.slave   bus,
    output logic [CNT_WIDTH-1:0] cnt_pkt_o,
    output logic [CNT_WIDTH-1:0] cnt_null_o,
    output logic [CNT_WIDTH-1:0] cnt_frame_err_o,
    output logic [CNT_WIDTH-1:0] cnt_ovf_o,
    output logic                 ovf_sticky_o,
    output logic                 dbg_state_o
);
    localparam int N_BEATS = (PKT_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
    localparam int ASM_W   = N_BEATS * LINK_WIDTH;
    localparam int BCW     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int OW      = PW + 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BCW-1:0]     beat_q, beat_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic               pkt_done;
    logic               frame_err;

    logic [PKT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]        count_q, count_d;
    logic [PKT_WIDTH-1:0] head_q, head_d;
    logic                 valid_q;

    logic [PKT_WIDTH-1:0] pkt;
    logic                 pop, push, full, good, ovf, null_pkt;

    logic [CNT_WIDTH-1:0] cnt_pkt_q, cnt_null_q, cnt_err_q, cnt_ovf_q;
    logic                 sticky_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Framing state, beat counter and assembly register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
        end
    end

    // Next framing state: sof always restarts assembly, a non-sof beat with
    // no frame open is a framing error, the last beat completes the packet.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        asm_d     = asm_q;
        pkt_done  = 1'b0;
        frame_err = 1'b0;
        if (bus.link_valid) begin
            if (bus.link_sof) begin
                frame_err = (state_q == ST_COLLECT);
                asm_d = '0;
                asm_d[LINK_WIDTH-1:0] = bus.link_data;
                if (N_BEATS == 1) begin
                    pkt_done = 1'b1;
                    state_d  = ST_IDLE;
                    beat_d   = '0;
                end else begin
                    state_d = ST_COLLECT;
                    beat_d  = BCW'(1);
                end
            end else if (state_q == ST_IDLE) begin
                frame_err = 1'b1;
            end else begin
                asm_d[int'(beat_q)*LINK_WIDTH +: LINK_WIDTH] = bus.link_data;
                if (int'(beat_q) == N_BEATS - 1) begin
                    pkt_done = 1'b1;
                    state_d  = ST_IDLE;
                    beat_d   = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end
    end

    // Completed packet is taken straight from the next assembly value so it
    // can be written at the same edge as its last beat.
    assign pkt      = asm_d[PKT_WIDTH-1:0];
    assign pop      = valid_q & bus.mtc_ready_i;
    assign full     = (count_q == OW'(FIFO_DEPTH));
    assign good     = pkt_done & pkt[PKT_WIDTH-1];
    assign null_pkt = pkt_done & ~pkt[PKT_WIDTH-1];
    assign push     = good & (~full | pop);
    assign ovf      = good & full & ~pop;

    // Next FIFO occupancy, read pointer and head value; the head is
    // registered so mtc_o is the new head right after the edge.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = '0;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) head_d = pkt;
            else                                head_d = mem[rd_ptr_d];
        end
    end

    // FIFO storage; data entries need no reset since occupancy guards them.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= pkt;
    end

    // FIFO pointers, occupancy and registered output head.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
        end
    end

    // Saturating status counters and the overflow sticky flag.
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_pkt_q  <= '0;
            cnt_null_q <= '0;
            cnt_err_q  <= '0;
            cnt_ovf_q  <= '0;
            sticky_q   <= 1'b0;
        end else begin
            if (push)      cnt_pkt_q  <= sat_inc(cnt_pkt_q);
            if (null_pkt)  cnt_null_q <= sat_inc(cnt_null_q);
            if (frame_err) cnt_err_q  <= sat_inc(cnt_err_q);
            if (ovf) begin
                cnt_ovf_q <= sat_inc(cnt_ovf_q);
                sticky_q  <= 1'b1;
            end
        end
    end

    assign bus.mtc_o       = head_q;
    assign bus.mtc_valid_o = valid_q;
    assign cnt_pkt_o       = cnt_pkt_q;
    assign cnt_null_o      = cnt_null_q;
    assign cnt_frame_err_o = cnt_err_q;
    assign cnt_ovf_o       = cnt_ovf_q;
    assign ovf_sticky_o    = sticky_q;
    assign dbg_state_o     = (state_q == ST_COLLECT);
endmodule

// File: tb/tb_mtc_link_deframer.sv
// Bench for mtc_link_deframer with LINK_WIDTH=32, PKT_WIDTH=72 (3 beats).
module tb_mtc_link_deframer;
    localparam int LW = 32;
    localparam int PW = 72;
    localparam int CW = 16;
    localparam int DEPTH = 4;

    logic          clock;
    logic          rst;
    logic [CW-1:0] cnt_pkt_o, cnt_null_o, cnt_frame_err_o, cnt_ovf_o;
    logic          ovf_sticky_o;
    logic          dbg_state_o;

    mtc_link_deframer_if #(.LINK_WIDTH(LW), .PKT_WIDTH(PW)) bus ();

    mtc_link_deframer #(
        .LINK_WIDTH(LW), .PKT_WIDTH(PW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .bus             (bus),
        .cnt_pkt_o       (cnt_pkt_o),
        .cnt_null_o      (cnt_null_o),
        .cnt_frame_err_o (cnt_frame_err_o),
        .cnt_ovf_o       (cnt_ovf_o),
        .ovf_sticky_o    (ovf_sticky_o),
        .dbg_state_o     (dbg_state_o)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // scoreboard: expected FIFO contents plus a beat-list framing model
    logic [PW-1:0] exp_q[$];
    logic [LW-1:0] m_beats[$];
    int  m_pkt, m_null, m_err, m_ovf;
    bit  m_sticky;
    bit  rand_ready;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < (1 << CW) - 1) ? v + 1 : v;
    endfunction

    // Model one rising edge from the inputs that were applied to it.
    task automatic model_step();
        bit done;
        bit pop;
        bit full;
        logic [3*LW-1:0] whole;
        logic [PW-1:0] p;
        if (rst) begin
            exp_q.delete();
            m_beats.delete();
            m_pkt = 0; m_null = 0; m_err = 0; m_ovf = 0; m_sticky = 0;
            return;
        end
        pop  = (exp_q.size() > 0) && bus.mtc_ready_i;
        full = (exp_q.size() == DEPTH);
        done = 0;
        p    = '0;
        if (bus.link_valid) begin
            if (bus.link_sof) begin
                if (m_beats.size() > 0) m_err = sat(m_err);
                m_beats.delete();
                m_beats.push_back(bus.link_data);
            end else if (m_beats.size() == 0) begin
                m_err = sat(m_err);
            end else begin
                m_beats.push_back(bus.link_data);
            end
            if (m_beats.size() == 3) begin
                whole = {m_beats[2], m_beats[1], m_beats[0]};
                p = whole[PW-1:0];
                done = 1;
                m_beats.delete();
            end
        end
        if (pop) void'(exp_q.pop_front());
        if (done) begin
            if (!p[PW-1]) m_null = sat(m_null);
            else if (!full || pop) begin
                exp_q.push_back(p);
                m_pkt = sat(m_pkt);
            end else begin
                m_ovf = sat(m_ovf);
                m_sticky = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("valid", bus.mtc_valid_o, exp_q.size() != 0);
        chk("head", bus.mtc_o, (exp_q.size() != 0) ? exp_q[0] : '0);
        chk("cnt_pkt", cnt_pkt_o, m_pkt[CW-1:0]);
        chk("cnt_null", cnt_null_o, m_null[CW-1:0]);
        chk("cnt_err", cnt_frame_err_o, m_err[CW-1:0]);
        chk("cnt_ovf", cnt_ovf_o, m_ovf[CW-1:0]);
        chk("sticky", ovf_sticky_o, m_sticky);
    endtask

    // driver tasks
    task automatic tick();
        if (rand_ready) bus.mtc_ready_i = 1'($urandom_range(0, 1));
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input bit s, input logic [LW-1:0] d);
        bus.link_valid = v;
        bus.link_sof   = s;
        bus.link_data  = d;
    endtask

    task automatic beat(input bit s, input logic [LW-1:0] d);
        drive(1'b1, s, d);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(1'b0, 1'($urandom_range(0, 1)), $urandom);
            tick();
        end
    endtask

    task automatic send_frame(input logic [PW-1:0] p, input int gap);
        logic [31:0] r;
        r = $urandom;
        beat(1'b1, p[31:0]);
        idle(gap);
        beat(1'b0, p[63:32]);
        idle(gap);
        beat(1'b0, {r[23:0], p[71:64]});
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        repeat (n) tick();
        rst = 1'b0;
    endtask

    logic [PW-1:0] ovp [6];
    logic [PW-1:0] rp;

    initial begin
        rst = 1'b1;
        rand_ready = 0;
        bus.mtc_ready_i = 1'b1;
        drive(1'b0, 1'b0, '0);
        do_reset(2);
        chk("rst_valid", bus.mtc_valid_o, 1'b0);
        chk("rst_head", bus.mtc_o, 72'h0);
        chk("rst_state", dbg_state_o, 1'b0);

        // good frame, delivered for exactly one cycle
        send_frame(72'h80_01234567_89ABCDEF, 0);
        chk("good_head", bus.mtc_o, 72'h80_01234567_89ABCDEF);
        chk("good_vld", bus.mtc_valid_o, 1'b1);
        chk("good_cnt", cnt_pkt_o, 16'd1);
        idle(1);
        chk("good_pulse", bus.mtc_valid_o, 1'b0);

        // null packet
        do_reset(1);
        send_frame(72'h7F_01234567_89ABCDEF, 0);
        idle(1);
        chk("null_vld", bus.mtc_valid_o, 1'b0);
        chk("null_cnt", cnt_null_o, 16'd1);
        chk("null_pkt", cnt_pkt_o, 16'd0);

        // framing errors: stray beat, then sof at beat 1 that starts the good frame
        do_reset(1);
        beat(1'b0, 32'hDEADBEEF);
        beat(1'b1, 32'h11111111);
        beat(1'b1, 32'h33332222);
        beat(1'b0, 32'h55554444);
        beat(1'b0, 32'h000000C6);
        chk("ferr_cnt", cnt_frame_err_o, 16'd2);
        chk("ferr_head", bus.mtc_o, 72'hC6_55554444_33332222);
        chk("ferr_pkt", cnt_pkt_o, 16'd1);
        idle(1);

        // stalls between beats
        do_reset(1);
        send_frame(72'h9A_0BADF00D_CAFEBABE, 2);
        chk("stall_head", bus.mtc_o, 72'h9A_0BADF00D_CAFEBABE);
        chk("stall_err", cnt_frame_err_o, 16'd0);
        idle(1);

        // overflow with ready low, then drain in order
        do_reset(1);
        bus.mtc_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ovp[i] = {8'h80 + 8'(i), 32'hA5A50000 + 32'(i), 32'h00001000 * 32'(i + 1)};
            send_frame(ovp[i], 0);
        end
        chk("ovf_vld", bus.mtc_valid_o, 1'b1);
        chk("ovf_head", bus.mtc_o, ovp[0]);
        chk("ovf_pkt", cnt_pkt_o, 16'd4);
        chk("ovf_cnt", cnt_ovf_o, 16'd2);
        chk("ovf_sticky", ovf_sticky_o, 1'b1);
        bus.mtc_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain", bus.mtc_o, ovp[i]);
            idle(1);
        end
        chk("drain_empty", bus.mtc_valid_o, 1'b0);

        // reset mid-frame clears everything, including the sticky flag
        beat(1'b1, 32'h12345678);
        beat(1'b0, 32'h9ABCDEF0);
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        tick();
        rst = 1'b0;
        chk("mrst_vld", bus.mtc_valid_o, 1'b0);
        chk("mrst_head", bus.mtc_o, 72'h0);
        chk("mrst_pkt", cnt_pkt_o, 16'd0);
        chk("mrst_ovf", cnt_ovf_o, 16'd0);
        chk("mrst_sticky", ovf_sticky_o, 1'b0);
        chk("mrst_state", dbg_state_o, 1'b0);
        send_frame(72'hF0_76543210_FEDCBA98, 0);
        chk("mrst_head2", bus.mtc_o, 72'hF0_76543210_FEDCBA98);
        chk("mrst_err", cnt_frame_err_o, 16'd0);
        idle(1);

        // randomized traffic against the model
        rand_ready = 1;
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            rp = {$urandom, $urandom, $urandom};
            rp[71] = ($urandom_range(0, 3) != 0);
            if (kind == 0) begin
                beat(1'b0, $urandom);
            end else if (kind == 1) begin
                beat(1'b1, rp[31:0]);
                beat(1'b0, rp[63:32]);
            end else begin
                send_frame(rp, $urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        rand_ready = 0;
        bus.mtc_ready_i = 1'b1;
        idle(8);
        chk("final_empty", bus.mtc_valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
